stash_scan_reader: RTL

// Read side of the stash scan table. After scan completes, walks scan table bucket-by-bucket,

---
 rtl/stash_scan_reader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/stash_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : stash_scan_reader
// Brief    : Walks the stash scan table slot by slot, clearing each slot as it
//            is read, and streams entry addresses (or dummies) to write-back.
//            Option macro SCAN_READ_LEAF_FIRST_EN walks levels leaf-to-root.
// Revision : 1.0  initial release
// ============================================================================
module stash_scan_reader #(
  parameter int ORAML        = 10,
  parameter int ORAMZ        = 4,
  parameter int BCWidth      = 3,
  parameter int BucketAWidth = 4,
  parameter int StashEAWidth = 8,
  parameter logic [StashEAWidth-1:0] SNULL = {StashEAWidth{1'b1}}
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic                           Start,
  output logic                           Busy,
  output logic                           Done,
  output logic [BucketAWidth+BCWidth-1:0] STAddr,
  output logic                           STValid,
  output logic                           STReset,
  input  logic [StashEAWidth-1:0]        STData,
  output logic [StashEAWidth-1:0]        OutSAddr,
  output logic [BucketAWidth-1:0]        OutLevel,
  output logic                           OutDummy,
  output logic                           OutValid,
  input  logic                           OutReady
);

  localparam int c_entryWidth = StashEAWidth + BucketAWidth;
  localparam logic [BCWidth-1:0] c_lastSlot = BCWidth'(ORAMZ - 1);
`ifdef SCAN_READ_LEAF_FIRST_EN
  localparam logic [BucketAWidth-1:0] c_firstLevel = BucketAWidth'(ORAML);
  localparam logic [BucketAWidth-1:0] c_lastLevel  = '0;
`else
  localparam logic [BucketAWidth-1:0] c_firstLevel = '0;
  localparam logic [BucketAWidth-1:0] c_lastLevel  = BucketAWidth'(ORAML);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } stateT;

  stateT                     r_state;
  stateT                     w_stateNext;
  logic [BucketAWidth-1:0]   r_level;
  logic [BCWidth-1:0]        r_slot;
  logic                      r_inFlight;
  logic [BucketAWidth-1:0]   r_reqLevel;
  logic [c_entryWidth-1:0]   r_fifo [2];
  logic                      r_wrPtr;
  logic                      r_rdPtr;
  logic [1:0]                r_occ;
  logic                      w_issue;
  logic                      w_pop;
  logic                      w_enq;
  logic                      w_fifoPop;
  logic                      w_lastIssue;
  logic [2:0]                w_pending;
  logic [BucketAWidth-1:0]   w_levelStep;
  logic [c_entryWidth-1:0]   w_head;

  // The in-flight read behaves as a virtual FIFO slot: its data is presented
  // directly when the FIFO is empty, giving one cycle of read-to-output latency.
  assign OutValid  = (r_occ != 2'd0) | r_inFlight;
  assign w_head    = (r_occ != 2'd0) ? r_fifo[r_rdPtr] : {STData, r_reqLevel};
  assign OutSAddr  = w_head[c_entryWidth-1:BucketAWidth];
  assign OutLevel  = w_head[BucketAWidth-1:0];
  assign OutDummy  = (OutSAddr == SNULL);
  assign w_pop     = OutValid & OutReady;
  assign w_enq     = r_inFlight & ~((r_occ == 2'd0) & w_pop);
  assign w_fifoPop = w_pop & (r_occ != 2'd0);
  assign w_pending = {1'b0, r_occ} + {2'b00, r_inFlight} - {2'b00, w_pop};

  assign w_lastIssue = (r_level == c_lastLevel) && (r_slot == c_lastSlot);
`ifdef SCAN_READ_LEAF_FIRST_EN
  assign w_levelStep = r_level - 1'b1;
`else
  assign w_levelStep = r_level + 1'b1;
`endif

  assign STAddr  = {r_level, r_slot};
  assign STValid = w_issue;
  assign STReset = w_issue;
  assign Busy    = (r_state == S_SCAN) || (r_state == S_DRAIN);
  assign Done    = (r_state == S_DONE);

  always_comb begin
    w_stateNext = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) w_stateNext = S_SCAN;
      end
      S_SCAN: begin
        w_issue = ~Reset & (w_pending < 3'd2);
        if (w_issue && w_lastIssue) w_stateNext = S_DRAIN;
      end
      S_DRAIN: begin
        // w_pending is the occupancy after this cycle; no reads issue here.
        if (w_pending == 3'd0) w_stateNext = S_DONE;
      end
      S_DONE: begin
        w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_level    <= '0;
      r_slot     <= '0;
      r_inFlight <= 1'b0;
      r_reqLevel <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_inFlight <= w_issue;
      if (r_state == S_IDLE && Start) begin
        r_level <= c_firstLevel;
        r_slot  <= '0;
      end else if (w_issue) begin
        r_reqLevel <= r_level;
        if (r_slot == c_lastSlot) begin
          r_slot  <= '0;
          r_level <= w_levelStep;
        end else begin
          r_slot <= r_slot + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_occ   <= 2'd0;
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
    end else begin
      if (w_enq) begin
        r_fifo[r_wrPtr] <= {STData, r_reqLevel};
        r_wrPtr         <= ~r_wrPtr;
      end
      if (w_fifoPop) r_rdPtr <= ~r_rdPtr;
      r_occ <= r_occ + {1'b0, w_enq} - {1'b0, w_fifoPop};
    end
  end

endmodule
`default_nettype wire
